// File: rtl/ow_reset_cmd_master.sv
// 1-Wire master: reset/presence handshake, LSB-first command byte, then ROM reader enable.
// Optional build macro OW_RETRY_EN: retry a failed presence detect up to three more times.
module ow_reset_cmd_master #(
    parameter int         T_RST_LOW     = 480,
    parameter int         T_PRES_SAMPLE = 70,
    parameter int         T_RST_HIGH    = 410,
    parameter int         T_W1_LOW      = 6,
    parameter int         T_W0_LOW      = 60,
    parameter int         T_SLOT        = 70,
    parameter int         T_REC         = 10,
    parameter logic [7:0] CMD_DEFAULT   = 8'h33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmd_sel,
    input  logic [7:0] cmd_byte,
    input  logic       bus,
    output logic       master_pull_low,
    output logic       busy,
    output logic       presence_ok,
    output logic       no_presence,
    output logic       en_read_rom,
    input  logic       done_reading_rom
);

    localparam int MAX_A   = (T_RST_LOW > T_RST_HIGH) ? T_RST_LOW : T_RST_HIGH;
    localparam int CNT_MAX = (MAX_A > T_SLOT + T_REC) ? MAX_A : T_SLOT + T_REC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(T_RST_LOW - 1);
    localparam logic [CNT_W-1:0] PRES_LAST     = CNT_W'(T_PRES_SAMPLE - 1);
    localparam logic [CNT_W-1:0] RST_HIGH_LAST = CNT_W'(T_RST_HIGH - 1);
    localparam logic [CNT_W-1:0] W1_LAST       = CNT_W'(T_W1_LOW - 1);
    localparam logic [CNT_W-1:0] W0_LAST       = CNT_W'(T_W0_LOW - 1);
    localparam logic [CNT_W-1:0] H1_LAST       = CNT_W'(T_SLOT - T_W1_LOW + T_REC - 1);
    localparam logic [CNT_W-1:0] H0_LAST       = CNT_W'(T_SLOT - T_W0_LOW + T_REC - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_LOW  = 3'd1;
    localparam logic [2:0] S_RST_HIGH = 3'd2;
    localparam logic [2:0] S_BIT_LOW  = 3'd3;
    localparam logic [2:0] S_BIT_HIGH = 3'd4;
    localparam logic [2:0] S_ARM      = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             pres_q, pres_d;
    logic             presence_ok_q, presence_ok_d;
    logic             no_presence_q, no_presence_d;
    logic             busy_q, busy_d;
    logic             mpl_q, mpl_d;
    logic             en_q, en_d;
`ifdef OW_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        shift_d       = shift_q;
        bit_idx_d     = bit_idx_q;
        pres_d        = pres_q;
        presence_ok_d = presence_ok_q;
        no_presence_d = no_presence_q;
`ifdef OW_RETRY_EN
        retry_d       = retry_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    shift_d       = cmd_sel ? cmd_byte : CMD_DEFAULT;
                    bit_idx_d     = 3'd0;
                    pres_d        = 1'b0;
                    presence_ok_d = 1'b0;
                    no_presence_d = 1'b0;
`ifdef OW_RETRY_EN
                    retry_d       = 2'd0;
`endif
                    state_d       = S_RST_LOW;
                end
            end

            S_RST_LOW: begin
                if (cnt_q == RST_LOW_LAST) begin
                    state_d = S_RST_HIGH;
                end
            end

            S_RST_HIGH: begin
                if (cnt_q == PRES_LAST) begin
                    pres_d = ~bus;
                end
                if (cnt_q == RST_HIGH_LAST) begin
                    if (pres_q) begin
                        presence_ok_d = 1'b1;
                        state_d       = S_BIT_LOW;
                    end else begin
`ifdef OW_RETRY_EN
                        if (retry_q != 2'd3) begin
                            retry_d = retry_q + 2'd1;
                            state_d = S_RST_LOW;
                        end else begin
                            no_presence_d = 1'b1;
                            state_d       = S_IDLE;
                        end
`else
                        no_presence_d = 1'b1;
                        state_d       = S_IDLE;
`endif
                    end
                end
            end

            S_BIT_LOW: begin
                if (cnt_q == (shift_q[0] ? W1_LAST : W0_LAST)) begin
                    state_d = S_BIT_HIGH;
                end
            end

            S_BIT_HIGH: begin
                // Release time plus recovery, so every slot totals T_SLOT + T_REC.
                if (cnt_q == (shift_q[0] ? H1_LAST : H0_LAST)) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    state_d   = (bit_idx_q == 3'd7) ? S_ARM : S_BIT_LOW;
                end
            end

            S_ARM: begin
                // cnt_q==0 marks the first ARM cycle; a done flag left over from before is ignored there.
                cnt_d = CNT_W'(1);
                if (done_reading_rom && (cnt_q != '0)) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        mpl_d  = (state_d == S_RST_LOW) || (state_d == S_BIT_LOW);
        busy_d = (state_d != S_IDLE);
        en_d   = (state_d == S_ARM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            pres_q        <= 1'b0;
            presence_ok_q <= 1'b0;
            no_presence_q <= 1'b0;
            busy_q        <= 1'b0;
            mpl_q         <= 1'b0;
            en_q          <= 1'b0;
`ifdef OW_RETRY_EN
            retry_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            pres_q        <= pres_d;
            presence_ok_q <= presence_ok_d;
            no_presence_q <= no_presence_d;
            busy_q        <= busy_d;
            mpl_q         <= mpl_d;
            en_q          <= en_d;
`ifdef OW_RETRY_EN
            retry_q       <= retry_d;
`endif
        end
    end

    assign master_pull_low = mpl_q;
    assign busy            = busy_q;
    assign presence_ok     = presence_ok_q;
    assign no_presence     = no_presence_q;
    assign en_read_rom     = en_q;

endmodule
